alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle successor to the combinational core ALU.
//  Same opcode map, plus WIDTH-generic datapath, start/busy/done handshake,
//  registered results and flags, and iterative MUL/DIV (one bit per clock).
//  Sits between the decoder/sequencer and the accumulator/PSW register file.
// PARAMETERS
//  WIDTH  8  operand width in bits; must be a multiple of 4 and >= 8
// PORTS
//  clk     in   1        single clock, all logic on rising edge
//  rst     in   1        synchronous, active-high reset
//  start   in   1        launch op; sampled only in IDLE
//  opcode  in   4        operation select (see BEHAVIOUR)
//  src_1   in   WIDTH    operand A / pointer high
//  src_2   in   WIDTH    operand B / rotate amount / pointer low
//  src_3   in   WIDTH    offset for pointer ops
//  p_cy    in   1        carry-in (PSW.CY)
//  p_ac    in   1        aux-carry-in (PSW.AC), used by DA
//  busy    out  1        high while an op is in progress
//  done    out  1        one-cycle pulse when dest/flags are valid
//  dest    out  2*WIDTH  result
//  cy      out  1        carry / borrow
//  ac      out  1        carry/borrow out of bit 3
//  ov      out  1        overflow
// BEHAVIOUR
//  Reset: busy=0, done=0, dest=0, cy=0, ac=0, ov=0; FSM->IDLE.
//  Reset mid-op aborts it: no done pulse; outputs take reset values.
//  FSM: IDLE -start-> EXEC (latch opcode/operands) -last step-> DONE -> IDLE.
//   busy=1 in EXEC and DONE; done=1 only in DONE.
//   start while busy is ignored; operands are latched, so inputs may change.
//   dest/flags update only on entry to DONE; held until next op's DONE.
//  Latency (start edge to done): 2 cycles for single-step ops;
//   MUL/DIV: WIDTH+1 cycles (WIDTH EXEC iterations).
//   Back-to-back: next start accepted in the cycle after done.
//  Arithmetic (mod 2^WIDTH, dest upper half 0 unless stated):
//   0000 NOP : dest/flags unchanged, done still pulses
//   0001 ADD : A+B+p_cy; cy=carry out, ac=carry from bit3, ov=signed ovf
//   0010 SUB : A-B-p_cy; cy=borrow, ac=borrow into bit4, ov=signed ovf
//   0011 MUL : shift-add, unsigned; dest=A*B; ov=(dest[2W-1:W]!=0), cy=0
//   0100 DIV : restoring; dest={quot,rem}; cy=0, ov=0
//      B==0: single step; dest={all ones, A}, ov=1, cy=0
//   0101 DA  : low 8 bits of A; +06 if low nibble>9 or p_ac; then
//      +60 if high nibble>9 or p_cy; cy=p_cy|carry out; bits above 7 pass
//   0110 NOT ~A; 0111 AND; 1000 XOR; 1001 OR : cy=ac=ov=0
//   1010 RL / 1100 RR : rotate A by (B mod WIDTH); flags unchanged
//   1011 RLC / 1101 RRC : rotate {p_cy,A} by (B mod WIDTH+1); cy=new
//      carry bit, amount 0 gives dest=A, cy=p_cy; ac/ov unchanged
//   1110 PREL: {A,B} + sign-extended src_3, mod 2^(2W); flags unchanged
//   1111 PABS: {A,B} + zero-extended src_3, mod 2^(2W); flags unchanged
//  Flags "unchanged" keep their previous registered value.
// TESTING (WIDTH=8)
//  ADD 7F+01, p_cy=0 -> dest 0080, cy0 ac1 ov1; done 2 cycles after start
//  SUB 00-01, p_cy=0 -> dest 00FF, cy1 ac1 ov0
//  MUL FF*FF -> dest FE01, ov1, done at cycle 9; start held at
//   cycles 2..8 ignored, busy=1 throughout
//  DIV 64/07 -> dest 0E02, ov0; DIV 55/00 -> dest FF55, ov1, latency 2
//  RLC A=81 B=01 p_cy=0 -> dest 0002, cy1; RR A=01 B=09 -> dest 0080
//  DA A=9B p_ac=0 p_cy=0 -> dest 0001, cy1; PREL A=12 B=00 src_3=FE -> 11FE
//  rst asserted at cycle 4 of MUL -> no done; outputs 0 next cycle;
//   new ADD accepted immediately after rst deasserts

Source files
------------

// File: rtl/alu_mc_if.sv
// Operand/result bus between the sequencer and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [3:0]           opcode;
  logic [WIDTH-1:0]     src_1;
  logic [WIDTH-1:0]     src_2;
  logic [WIDTH-1:0]     src_3;
  logic                 p_cy;
  logic                 p_ac;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dest;
  logic                 cy;
  logic                 ac;
  logic                 ov;

  modport master (
    output start, opcode, src_1, src_2, src_3, p_cy, p_ac,
    input  busy, done, dest, cy, ac, ov
  );

  modport slave (
    input  start, opcode, src_1, src_2, src_3, p_cy, p_ac,
    output busy, done, dest, cy, ac, ov
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-step logic/arithmetic ops, iterative shift-add
// MUL and restoring DIV (one bit per clock), registered result and flags.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  localparam int             CW     = $clog2(WIDTH);
  localparam logic [WIDTH:0] W_ONLY = (WIDTH+1)'(WIDTH);
  localparam logic [WIDTH:0] W_P1   = (WIDTH+1)'(WIDTH + 1);

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4, OP_DA  = 4'h5, OP_NOT = 4'h6, OP_AND = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8, OP_OR  = 4'h9, OP_RL  = 4'hA, OP_RLC = 4'hB;
  localparam logic [3:0] OP_RR  = 4'hC, OP_RRC = 4'hD, OP_PREL = 4'hE, OP_PABS = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  function automatic logic [WIDTH-1:0] rotl_w(input logic [WIDTH-1:0] v, input logic [WIDTH:0] n);
    return (v << n) | (v >> (W_ONLY - n));
  endfunction

  function automatic logic [WIDTH-1:0] rotr_w(input logic [WIDTH-1:0] v, input logic [WIDTH:0] n);
    return (v >> n) | (v << (W_ONLY - n));
  endfunction

  function automatic logic [WIDTH:0] rotl_c(input logic [WIDTH:0] v, input logic [WIDTH:0] n);
    return (v << n) | (v >> (W_P1 - n));
  endfunction

  function automatic logic [WIDTH:0] rotr_c(input logic [WIDTH:0] v, input logic [WIDTH:0] n);
    return (v >> n) | (v << (W_P1 - n));
  endfunction

  state_t               state;
  logic                 busy_r, done_r, cy_r, ac_r, ov_r;
  logic [2*WIDTH-1:0]   dest_r;
  logic [3:0]           op_r;
  logic [WIDTH-1:0]     a_r, b_r, c_r;
  logic                 pcy_r, pac_r;
  logic [2*WIDTH-1:0]   acc, mc_a, acc_nx;
  logic [WIDTH-1:0]     mc_b, rem, quot, rem_nx, quot_nx;
  logic [WIDTH:0]       rem_sh;
  logic                 div_ge;
  logic [CW-1:0]        cnt;

  logic [2*WIDTH-1:0]   res_dest;
  logic                 res_cy, res_ac, res_ov;
  logic [WIDTH:0]       sum, amt_w, amt_c, rc_v;
  logic [8:0]           da_t;
  logic [WIDTH-1:0]     da_w;
  logic signed [2*WIDTH-1:0] ofs_s;

  // One iteration of the shift-add multiplier and the restoring divider.
  always_comb begin
    acc_nx  = acc + (mc_b[0] ? mc_a : '0);
    rem_sh  = {rem, quot[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, b_r});
    rem_nx  = div_ge ? (rem_sh[WIDTH-1:0] - b_r) : rem_sh[WIDTH-1:0];
    quot_nx = {quot[WIDTH-2:0], div_ge};
  end

  // Result and flags of every op that completes in a single EXEC cycle.
  always_comb begin
    res_dest = dest_r;
    res_cy   = cy_r;
    res_ac   = ac_r;
    res_ov   = ov_r;
    sum      = '0;
    amt_w    = {1'b0, b_r} % W_ONLY;
    amt_c    = {1'b0, b_r} % W_P1;
    rc_v     = '0;
    da_t     = {1'b0, a_r[7:0]};
    da_w     = a_r;
    ofs_s    = (2*WIDTH)'(signed'(c_r));
    case (op_r)
      OP_ADD: begin
        sum      = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, pcy_r};
        res_dest = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        res_cy   = sum[WIDTH];
        res_ac   = a_r[4] ^ b_r[4] ^ sum[4];
        res_ov   = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        sum      = {1'b0, a_r} - {1'b0, b_r} - {{WIDTH{1'b0}}, pcy_r};
        res_dest = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        res_cy   = sum[WIDTH];
        res_ac   = a_r[4] ^ b_r[4] ^ sum[4];
        res_ov   = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_DIV: begin
        // Only the divide-by-zero case finishes in one step.
        res_dest = {{WIDTH{1'b1}}, a_r};
        res_cy   = 1'b0;
        res_ov   = 1'b1;
      end
      OP_DA: begin
        if (a_r[3:0] > 4'd9 || pac_r) da_t = da_t + 9'h006;
        if (da_t[7:4] > 4'd9 || pcy_r) da_t = da_t + 9'h060;
        da_w[7:0] = da_t[7:0];
        res_dest  = {{WIDTH{1'b0}}, da_w};
        res_cy    = pcy_r | da_t[8];
      end
      OP_NOT, OP_AND, OP_XOR, OP_OR: begin
        case (op_r)
          OP_NOT:  res_dest = {{WIDTH{1'b0}}, ~a_r};
          OP_AND:  res_dest = {{WIDTH{1'b0}}, a_r & b_r};
          OP_XOR:  res_dest = {{WIDTH{1'b0}}, a_r ^ b_r};
          default: res_dest = {{WIDTH{1'b0}}, a_r | b_r};
        endcase
        res_cy = 1'b0;
        res_ac = 1'b0;
        res_ov = 1'b0;
      end
      OP_RL: res_dest = {{WIDTH{1'b0}}, rotl_w(a_r, amt_w)};
      OP_RR: res_dest = {{WIDTH{1'b0}}, rotr_w(a_r, amt_w)};
      OP_RLC, OP_RRC: begin
        rc_v     = (op_r == OP_RLC) ? rotl_c({pcy_r, a_r}, amt_c) : rotr_c({pcy_r, a_r}, amt_c);
        res_dest = {{WIDTH{1'b0}}, rc_v[WIDTH-1:0]};
        res_cy   = rc_v[WIDTH];
      end
      OP_PREL: res_dest = {a_r, b_r} + $unsigned(ofs_s);
      OP_PABS: res_dest = {a_r, b_r} + {{WIDTH{1'b0}}, c_r};
      default: ;
    endcase
  end

  // Control FSM plus operand latch, iteration state and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dest_r <= '0;
      cy_r   <= 1'b0;
      ac_r   <= 1'b0;
      ov_r   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r   <= bus.opcode;
            a_r    <= bus.src_1;
            b_r    <= bus.src_2;
            c_r    <= bus.src_3;
            pcy_r  <= bus.p_cy;
            pac_r  <= bus.p_ac;
            acc    <= '0;
            mc_a   <= {{WIDTH{1'b0}}, bus.src_1};
            mc_b   <= bus.src_2;
            rem    <= '0;
            quot   <= bus.src_1;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (op_r == OP_MUL) begin
            acc  <= acc_nx;
            mc_a <= mc_a << 1;
            mc_b <= mc_b >> 1;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              dest_r <= acc_nx;
              cy_r   <= 1'b0;
              ov_r   <= (acc_nx[2*WIDTH-1:WIDTH] != '0);
              done_r <= 1'b1;
              state  <= S_DONE;
            end
          end else if (op_r == OP_DIV && b_r != '0) begin
            rem  <= rem_nx;
            quot <= quot_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              dest_r <= {quot_nx, rem_nx};
              cy_r   <= 1'b0;
              ov_r   <= 1'b0;
              done_r <= 1'b1;
              state  <= S_DONE;
            end
          end else begin
            dest_r <= res_dest;
            cy_r   <= res_cy;
            ac_r   <= res_ac;
            ov_r   <= res_ov;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dest = dest_r;
  assign bus.cy   = cy_r;
  assign bus.ac   = ac_r;
  assign bus.ov   = ov_r;
endmodule
